// File: rtl/gps_srq_sched_pkg.sv
// Shared constants and FSM encoding for the GPS service-request scheduler.
package gps_srq_sched_pkg;

    localparam int unsigned NUM_CHANS = 12;
    localparam int unsigned SRQ_IDX_W = 4;

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } srq_state_t;

endpackage

// File: rtl/gps_srq_pick.sv
// Combinational picker: first eligible requester at or after start, wrapping modulo NREQ.
module gps_srq_pick
    import gps_srq_sched_pkg::*;
#(
    parameter int unsigned NREQ = NUM_CHANS + 1
) (
    input  logic [NREQ-1:0]      eligible,
    input  logic [SRQ_IDX_W-1:0] start,
    output logic [SRQ_IDX_W-1:0] winner,
    output logic                 any_valid
);

    logic [SRQ_IDX_W-1:0] cand;
    int                   pos;

    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        cand      = '0;
        pos       = 0;
        for (int k = 0; k < int'(NREQ); k++) begin
            pos  = (int'(start) + k) % int'(NREQ);
            cand = SRQ_IDX_W'(pos);
            if (!any_valid && eligible[cand]) begin
                any_valid = 1'b1;
                winner    = cand;
            end
        end
    end

endmodule

// File: rtl/gps_srq_sched.sv
// Service-request scheduler: latches demod epoch pulses and host request, grants one at a time.
// Define GPS_SRQ_RR_EN for round-robin arbitration; default is fixed lowest-index-first.
module gps_srq_sched
    import gps_srq_sched_pkg::*;
#(
    parameter int unsigned GPS_CHANS = NUM_CHANS,
    parameter int unsigned TMO_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [GPS_CHANS-1:0] chan_srq,
    input  logic                 host_srq,
    input  logic                 wr_mask,
    input  logic [GPS_CHANS-1:0] mask_din,
    input  logic                 svc_ack,
    input  logic                 wr_flag_clr,
    output logic                 svc_valid,
    output logic [SRQ_IDX_W-1:0] svc_idx,
    output logic [GPS_CHANS:0]   pending,
    output logic [GPS_CHANS-1:0] ovr_flags,
    output logic                 tmo_flag
);

    localparam int unsigned          NREQ     = GPS_CHANS + 1;
    localparam logic [SRQ_IDX_W-1:0] HOST_IDX = SRQ_IDX_W'(GPS_CHANS);

    srq_state_t           state_q;
    logic [GPS_CHANS-1:0] chan_pend_q, chan_mask_q, ovr_q, clr_vec;
    logic                 host_pend_q, tmo_q, svc_valid_q;
    logic [SRQ_IDX_W-1:0] svc_idx_q, winner, start_idx;
    logic [TMO_BITS-1:0]  tmo_cnt_q, tmo_cnt_inc;
    logic [NREQ-1:0]      eligible;
    logic                 any_elig, tmo_hit, done;

    assign eligible    = {host_pend_q, chan_pend_q & chan_mask_q};
    assign tmo_cnt_inc = tmo_cnt_q + TMO_BITS'(1);
    assign tmo_hit     = (state_q == StGrant) && !svc_ack && (tmo_cnt_inc == '1);
    assign done        = (state_q == StGrant) && (svc_ack || tmo_hit);

    // Host bit is a registered level, so only channel bits are ever cleared.
    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < int'(GPS_CHANS); i++) begin
            clr_vec[i] = done && (svc_idx_q == SRQ_IDX_W'(i));
        end
    end

`ifdef GPS_SRQ_RR_EN
    logic [SRQ_IDX_W-1:0] last_grant_q;

    assign start_idx = (last_grant_q == HOST_IDX) ? '0 : last_grant_q + SRQ_IDX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= HOST_IDX;
        end else if (state_q == StIdle && any_elig) begin
            last_grant_q <= winner;
        end
    end
`else
    assign start_idx = '0;
`endif

    gps_srq_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .eligible  (eligible),
        .start     (start_idx),
        .winner    (winner),
        .any_valid (any_elig)
    );

    // A new epoch in the same cycle as its own clear is a fresh request, not an overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chan_pend_q <= '0;
            host_pend_q <= 1'b0;
            chan_mask_q <= '0;
            ovr_q       <= '0;
            tmo_q       <= 1'b0;
        end else begin
            chan_pend_q <= (chan_pend_q & ~clr_vec) | chan_srq;
            host_pend_q <= host_srq;
            ovr_q       <= (ovr_q & ~(wr_flag_clr ? mask_din : '0))
                         | (chan_srq & chan_pend_q & ~clr_vec);
            if (wr_mask) begin
                chan_mask_q <= mask_din;
            end
            if (tmo_hit) begin
                tmo_q <= 1'b1;
            end else if (wr_flag_clr && mask_din[0]) begin
                tmo_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            svc_valid_q <= 1'b0;
            svc_idx_q   <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_elig) begin
                        state_q     <= StGrant;
                        svc_valid_q <= 1'b1;
                        svc_idx_q   <= winner;
                        tmo_cnt_q   <= '0;
                    end
                end
                StGrant: begin
                    if (done) begin
                        state_q     <= StIdle;
                        svc_valid_q <= 1'b0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_inc;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    svc_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign svc_valid = svc_valid_q;
    assign svc_idx   = svc_idx_q;
    assign pending   = {host_pend_q, chan_pend_q};
    assign ovr_flags = ovr_q;
    assign tmo_flag  = tmo_q;

endmodule

// File: tb/tb_gps_srq_sched.sv
// Directed bench for gps_srq_sched (fixed-priority build, short timeout counter).
module tb_gps_srq_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] chan_srq = '0;
    logic        host_srq = 1'b0;
    logic        wr_mask = 1'b0;
    logic [11:0] mask_din = '0;
    logic        svc_ack = 1'b0;
    logic        wr_flag_clr = 1'b0;
    logic        svc_valid;
    logic [3:0]  svc_idx;
    logic [12:0] pending;
    logic [11:0] ovr_flags;
    logic        tmo_flag;

    int checks = 0;
    int errors = 0;

    gps_srq_sched #(
        .GPS_CHANS (12),
        .TMO_BITS  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .chan_srq    (chan_srq),
        .host_srq    (host_srq),
        .wr_mask     (wr_mask),
        .mask_din    (mask_din),
        .svc_ack     (svc_ack),
        .wr_flag_clr (wr_flag_clr),
        .svc_valid   (svc_valid),
        .svc_idx     (svc_idx),
        .pending     (pending),
        .ovr_flags   (ovr_flags),
        .tmo_flag    (tmo_flag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] srq;
        logic        host;
        logic        wm;
        logic [11:0] din;
        logic        ack;
        logic        fc;
        logic        sv;
        logic [3:0]  idx;
        logic [12:0] pend;
        logic [11:0] ovr;
        logic        tmo;
    } vec_t;

    vec_t vecs[26];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic sv, input logic [3:0] idx,
                           input logic [12:0] pend, input logic [11:0] ovr, input logic tmo);
        chk({name, ".svc_valid"}, 32'(svc_valid), 32'(sv));
        chk({name, ".svc_idx"}, 32'(svc_idx), 32'(idx));
        chk({name, ".pending"}, 32'(pending), 32'(pend));
        chk({name, ".ovr_flags"}, 32'(ovr_flags), 32'(ovr));
        chk({name, ".tmo_flag"}, 32'(tmo_flag), 32'(tmo));
    endtask

    // Drive one cycle of inputs at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic [11:0] srq, input logic host, input logic wm,
                        input logic [11:0] din, input logic ack, input logic fc);
        @(negedge clk);
        chan_srq    = srq;
        host_srq    = host;
        wr_mask     = wm;
        mask_din    = din;
        svc_ack     = ack;
        wr_flag_clr = fc;
        @(posedge clk);
        #1;
    endtask

    task automatic grant_ch0_timeout(input string name);
        step(12'h001, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
        chk({name, ".pend0"}, 32'(pending), 32'h001);
        step(12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
        chk({name, ".grant_valid"}, 32'(svc_valid), 32'h1);
        chk({name, ".grant_idx"}, 32'(svc_idx), 32'h0);
        for (int k = 1; k <= 14; k++) begin
            step(12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
            chk({name, ".still_granted"}, 32'(svc_valid), 32'h1);
        end
        step(12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0);
        chk_all({name, ".expired"}, 1'b0, 4'd0, 13'h0000, 12'h000, 1'b1);
    endtask

    initial begin
        //          srq      host  wm    din      ack   fc    sv    idx   pend      ovr      tmo
        vecs[0]  = {12'h000, 1'b0, 1'b1, 12'hFFF, 1'b0, 1'b0, 1'b0, 4'd0, 13'h0000, 12'h000, 1'b0};
        vecs[1]  = {12'h020, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 4'd0, 13'h0020, 12'h000, 1'b0};
        vecs[2]  = {12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 4'd5, 13'h0020, 12'h000, 1'b0};
        vecs[3]  = {12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 4'd5, 13'h0000, 12'h000, 1'b0};
        vecs[4]  = {12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 4'd5, 13'h0000, 12'h000, 1'b0};
        vecs[5]  = {12'h088, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 4'd5, 13'h0088, 12'h000, 1'b0};
        vecs[6]  = {12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 4'd3, 13'h0088, 12'h000, 1'b0};
        vecs[7]  = {12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 4'd3, 13'h0080, 12'h000, 1'b0};
        vecs[8]  = {12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 4'd7, 13'h0080, 12'h000, 1'b0};
        vecs[9]  = {12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 4'd7, 13'h0000, 12'h000, 1'b0};
        vecs[10] = {12'h000, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 4'd7, 13'h0000, 12'h000, 1'b0};
        vecs[11] = {12'h004, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 4'd7, 13'h0004, 12'h000, 1'b0};
        vecs[12] = {12'h004, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 4'd7, 13'h0004, 12'h004, 1'b0};
        vecs[13] = {12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 4'd7, 13'h0004, 12'h004, 1'b0};
        vecs[14] = {12'h000, 1'b0, 1'b0, 12'h004, 1'b0, 1'b1, 1'b0, 4'd7, 13'h0004, 12'h000, 1'b0};
        vecs[15] = {12'h000, 1'b0, 1'b1, 12'hFFF, 1'b0, 1'b0, 1'b0, 4'd7, 13'h0004, 12'h000, 1'b0};
        vecs[16] = {12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 4'd2, 13'h0004, 12'h000, 1'b0};
        vecs[17] = {12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 4'd2, 13'h0000, 12'h000, 1'b0};
        vecs[18] = {12'h010, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 4'd2, 13'h0010, 12'h000, 1'b0};
        vecs[19] = {12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 4'd4, 13'h0010, 12'h000, 1'b0};
        vecs[20] = {12'h010, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 4'd4, 13'h0010, 12'h000, 1'b0};
        vecs[21] = {12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 4'd4, 13'h0010, 12'h000, 1'b0};
        vecs[22] = {12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 4'd4, 13'h0000, 12'h000, 1'b0};
        vecs[23] = {12'h040, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 4'd4, 13'h0040, 12'h000, 1'b0};
        vecs[24] = {12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 4'd6, 13'h0040, 12'h000, 1'b0};
        vecs[25] = {12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 4'd6, 13'h0000, 12'h000, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 4'd0, 13'h0000, 12'h000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            step(vecs[i].srq, vecs[i].host, vecs[i].wm, vecs[i].din, vecs[i].ack, vecs[i].fc);
            chk_all($sformatf("vec%0d", i), vecs[i].sv, vecs[i].idx, vecs[i].pend,
                    vecs[i].ovr, vecs[i].tmo);
        end

        grant_ch0_timeout("tmo1");

        // Flag clear without bit 0 leaves the timeout flag alone.
        step(12'h000, 1'b0, 1'b0, 12'h002, 1'b0, 1'b1);
        chk("tmo_keep", 32'(tmo_flag), 32'h1);

        // Host request: lowest priority, level-sourced so ack does not clear it.
        step(12'h000, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
        chk("host_pend", 32'(pending), 32'h1000);
        chk("host_nogrant_yet", 32'(svc_valid), 32'h0);
        step(12'h000, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
        chk_all("host_grant", 1'b1, 4'd12, 13'h1000, 12'h000, 1'b1);
        step(12'h000, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
        chk_all("host_ack", 1'b0, 4'd12, 13'h1000, 12'h000, 1'b1);
        step(12'h000, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
        chk_all("host_regrant", 1'b1, 4'd12, 13'h1000, 12'h000, 1'b1);
        step(12'h200, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
        chk_all("ch9_during_host", 1'b1, 4'd12, 13'h1200, 12'h000, 1'b1);
        step(12'h200, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0);
        chk_all("ch9_overrun", 1'b1, 4'd12, 13'h1200, 12'h200, 1'b1);

        // Asynchronous reset between clock edges while granted.
        @(negedge clk);
        chan_srq = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 1'b0, 4'd0, 13'h0000, 12'h000, 1'b0);
        host_srq = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset_held", 1'b0, 4'd0, 13'h0000, 12'h000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Mask is zero after reset: re-enable, time out again, then clear via bit 0.
        step(12'h000, 1'b0, 1'b1, 12'hFFF, 1'b0, 1'b0);
        grant_ch0_timeout("tmo2");
        step(12'h000, 1'b0, 1'b0, 12'h001, 1'b0, 1'b1);
        chk("tmo_clear", 32'(tmo_flag), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
